// File: rtl/rv_trace_pkg.sv
// Shared types, decoder and (with RV_DISASM_TRACE_EN) disassembly helpers for the RV32 trace stage.
package rv_trace_pkg;

  typedef enum logic [2:0] {
    OP_LUI     = 3'd0,
    OP_AUIPC   = 3'd1,
    OP_JAL     = 3'd2,
    OP_ADDI    = 3'd3,
    OP_ADD     = 3'd4,
    OP_ILLEGAL = 3'd5
  } op_t;

  typedef struct packed {
    logic [31:0] pc;
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } trace_rec_t;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  function automatic trace_rec_t decode(input logic [31:0] pc, input logic [31:0] insn);
    trace_rec_t r;
    r = '0;
    r.pc = pc;
    r.op = OP_ILLEGAL;
    case (insn[6:0])
      OPC_LUI: begin
        r.op  = OP_LUI;
        r.rd  = insn[11:7];
        r.imm = {insn[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        r.op  = OP_AUIPC;
        r.rd  = insn[11:7];
        r.imm = {insn[31:12], 12'b0};
      end
      OPC_JAL: begin
        r.op  = OP_JAL;
        r.rd  = insn[11:7];
        r.imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      end
      OPC_OPIMM: begin
        if (insn[14:12] == 3'b000) begin
          r.op  = OP_ADDI;
          r.rd  = insn[11:7];
          r.rs1 = insn[19:15];
          r.imm = {{20{insn[31]}}, insn[31:20]};
        end
      end
      OPC_OP: begin
        if (insn[14:12] == 3'b000 && insn[31:25] == 7'b0000000) begin
          r.op  = OP_ADD;
          r.rd  = insn[11:7];
          r.rs1 = insn[19:15];
          r.rs2 = insn[24:20];
        end
      end
      default: ;
    endcase
    return r;
  endfunction

`ifdef RV_DISASM_TRACE_EN
  localparam string REG_ABI [0:31] = '{
    "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
    "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
    "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
    "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};

  localparam string REG_NUM [0:31] = '{
    "x0", "x1", "x2", "x3", "x4", "x5", "x6", "x7",
    "x8", "x9", "x10", "x11", "x12", "x13", "x14", "x15",
    "x16", "x17", "x18", "x19", "x20", "x21", "x22", "x23",
    "x24", "x25", "x26", "x27", "x28", "x29", "x30", "x31"};

  function automatic string reg_name(input logic [4:0] idx, input bit abi);
    return abi ? REG_ABI[idx] : REG_NUM[idx];
  endfunction

  function automatic string disasm(input trace_rec_t r, input bit abi);
    string mn;
    string ops;
    mn  = "";
    ops = "";
    case (r.op)
      OP_LUI:   begin mn = "lui";   ops = $sformatf("%s, 0x%08x", reg_name(r.rd, abi), r.imm); end
      OP_AUIPC: begin mn = "auipc"; ops = $sformatf("%s, 0x%08x", reg_name(r.rd, abi), r.imm); end
      OP_JAL:   begin mn = "jal";   ops = $sformatf("%s, 0x%08x", reg_name(r.rd, abi), r.imm); end
      OP_ADDI:  begin
        mn  = "addi";
        ops = $sformatf("%s, %s, 0x%08x", reg_name(r.rd, abi), reg_name(r.rs1, abi), r.imm);
      end
      OP_ADD:   begin
        mn  = "add";
        ops = $sformatf("%s, %s, %s", reg_name(r.rd, abi), reg_name(r.rs1, abi),
                        reg_name(r.rs2, abi));
      end
      default:  return "illegal";
    endcase
    while (mn.len() < 6) mn = {mn, " "};
    return {mn, ops};
  endfunction
`endif

endpackage

// File: rtl/rv_trace_fifo.sv
// DEPTH-entry synchronous FIFO of decoded trace records; no bypass in either direction.
module rv_trace_fifo
  import rv_trace_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  trace_rec_t  wdata,
  output trace_rec_t  rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  trace_rec_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv_disasm_trace.sv
// Buffered RV32 trace decoder: decode on push, FIFO of records, pop statistics.
// Define RV_DISASM_TRACE_EN to print one disassembly line per popped record.
module rv_disasm_trace
  import rv_trace_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ABI_NAMES = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_insn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output op_t              out_op,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ABI_NAMES < 0 || ABI_NAMES > 1) begin : g_bad_cfg
    $error("rv_disasm_trace: DEPTH must be a power of two >= 2 and ABI_NAMES 0 or 1");
  end

  trace_rec_t                 push_rec;
  trace_rec_t                 head;
  trace_rec_t                 shown;
  logic                       full;
  logic                       empty;
  logic [$clog2(DEPTH):0]     fill_cnt;
  logic                       do_pop;

  assign push_rec = decode(in_pc, in_insn);

  rv_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (out_ready),
    .wdata (push_rec),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fill_cnt)
  );

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign do_pop    = out_valid && out_ready;

  // Zero the fields while empty so stale or uninitialised storage never leaks out.
  assign shown   = empty ? '0 : head;
  assign out_pc  = shown.pc;
  assign out_op  = shown.op;
  assign out_rd  = shown.rd;
  assign out_rs1 = shown.rs1;
  assign out_rs2 = shown.rs2;
  assign out_imm = shown.imm;

  always_ff @(posedge clk) begin
    if (rst) begin
      decoded_cnt <= '0;
      illegal_cnt <= '0;
    end else if (do_pop) begin
      decoded_cnt <= decoded_cnt + 1'b1;
      if (head.op == OP_ILLEGAL) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (empty == (fill_cnt == '0));
  end

`ifdef RV_DISASM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && do_pop) $display("PC: 0x%08x: %s", head.pc, disasm(head, ABI_NAMES != 0));
  end
`endif

endmodule

// File: tb/tb_rv_disasm_trace.sv
// Self-checking bench for rv_disasm_trace: queue-based reference model plus directed literals.
module tb_rv_disasm_trace;
  import rv_trace_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_pc = '0;
  logic [31:0]      in_insn = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_pc;
  op_t              out_op;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [31:0]      out_imm;
  logic [CNT_W-1:0] decoded_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  trace_rec_t       q[$];
  logic [CNT_W-1:0] m_dec = '0;
  logic [CNT_W-1:0] m_ill = '0;

  rv_disasm_trace #(.DEPTH(DEPTH), .ABI_NAMES(1), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_insn     (in_insn),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_op      (out_op),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_imm     (out_imm),
    .decoded_cnt (decoded_cnt),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08x expected 0x%08x at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder: pick fields by opcode and sign-extend via integer conversion.
  function automatic trace_rec_t ref_decode(input logic [31:0] pc, input logic [31:0] insn);
    trace_rec_t r;
    logic signed [20:0] j21;
    logic signed [11:0] i12;
    int v;
    r.pc = pc; r.op = OP_ILLEGAL; r.rd = 0; r.rs1 = 0; r.rs2 = 0; r.imm = 0;
    j21 = {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    i12 = insn[31:20];
    if (insn[6:0] == 7'h37) begin
      r.op = OP_LUI; r.rd = insn[11:7]; r.imm = insn & 32'hFFFF_F000;
    end else if (insn[6:0] == 7'h17) begin
      r.op = OP_AUIPC; r.rd = insn[11:7]; r.imm = insn & 32'hFFFF_F000;
    end else if (insn[6:0] == 7'h6F) begin
      v = j21;
      r.op = OP_JAL; r.rd = insn[11:7]; r.imm = v;
    end else if (insn[6:0] == 7'h13 && insn[14:12] == 3'd0) begin
      v = i12;
      r.op = OP_ADDI; r.rd = insn[11:7]; r.rs1 = insn[19:15]; r.imm = v;
    end else if (insn[6:0] == 7'h33 && insn[14:12] == 3'd0 && insn[31:25] == 7'd0) begin
      r.op = OP_ADD; r.rd = insn[11:7]; r.rs1 = insn[19:15]; r.rs2 = insn[24:20];
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: w[6:0] = 7'h37;
      1: w[6:0] = 7'h17;
      2: w[6:0] = 7'h6F;
      3: begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
      4: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'd0; end
      5: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h20; end
      6: begin w[6:0] = 7'h13; w[14:12] = 3'($urandom_range(1, 7)); end
      default: ;
    endcase
    return w;
  endfunction

  // Model: handshake decisions are made on the state before the edge.
  always @(posedge clk) begin
    bit p, o;
    if (rst) begin
      q.delete();
      m_dec = '0;
      m_ill = '0;
    end else begin
      p = in_valid && (q.size() < DEPTH);
      o = out_ready && (q.size() > 0);
      if (o) begin
        m_dec = m_dec + 1'b1;
        if (q[0].op == OP_ILLEGAL) m_ill = m_ill + 1'b1;
        void'(q.pop_front());
      end
      if (p) q.push_back(ref_decode(in_pc, in_insn));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("decoded_cnt", 32'(decoded_cnt), 32'(m_dec));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
      if (q.size() != 0) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_op", 32'(out_op), 32'(q[0].op));
        chk("out_rd", 32'(out_rd), 32'(q[0].rd));
        chk("out_rs1", 32'(out_rs1), 32'(q[0].rs1));
        chk("out_rs2", 32'(out_rs2), 32'(q[0].rs2));
        chk("out_imm", out_imm, q[0].imm);
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] insn, input bit rdy);
    in_valid  = v;
    in_pc     = pc;
    in_insn   = insn;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    trace_rec_t r;
    @(posedge clk);
    #1;
    step(1'b0, '0, '0, 1'b0);
    rst    = 1'b0;
    chk_en = 1'b1;

    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset decoded_cnt", 32'(decoded_cnt), 32'd0);
    chk("reset illegal_cnt", 32'(illegal_cnt), 32'd0);

    r = ref_decode(32'h8000_0000, 32'h1234_5537);
    chk("model lui imm", r.imm, 32'h1234_5000);
    chk("model lui rd", 32'(r.rd), 32'd10);
    r = ref_decode(32'h0, 32'hFFDF_F06F);
    chk("model jal neg imm", r.imm, 32'hFFFF_FFFC);
    r = ref_decode(32'h0, 32'hFF01_0113);
    chk("model addi imm", r.imm, 32'hFFFF_FFF0);

    step(1'b1, 32'h8000_0000, 32'h1234_5537, 1'b0);
    chk("lui valid", 32'(out_valid), 32'd1);
    chk("lui op", 32'(out_op), 32'(OP_LUI));
    chk("lui rd", 32'(out_rd), 32'd10);
    chk("lui imm", out_imm, 32'h1234_5000);
    chk("lui pc", out_pc, 32'h8000_0000);

    step(1'b1, 32'h8000_0004, 32'hFF01_0113, 1'b0);
    step(1'b1, 32'h8000_0008, 32'h0073_02B3, 1'b0);
    step(1'b1, 32'h8000_000C, 32'h0080_00EF, 1'b0);
    chk("full in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 32'h8000_0010, 32'hFFDF_F06F, 1'b0);
    chk("refused head pc", out_pc, 32'h8000_0000);
    step(1'b0, '0, '0, 1'b1);
    chk("after pop in_ready", 32'(in_ready), 32'd1);
    chk("addi op", 32'(out_op), 32'(OP_ADDI));
    chk("addi rd", 32'(out_rd), 32'd2);
    chk("addi rs1", 32'(out_rs1), 32'd2);
    chk("addi imm", out_imm, 32'hFFFF_FFF0);
    step(1'b0, '0, '0, 1'b1);
    chk("add op", 32'(out_op), 32'(OP_ADD));
    chk("add rd", 32'(out_rd), 32'd5);
    chk("add rs1", 32'(out_rs1), 32'd6);
    chk("add rs2", 32'(out_rs2), 32'd7);
    step(1'b0, '0, '0, 1'b1);
    chk("jal pc", out_pc, 32'h8000_000C);
    chk("jal imm", out_imm, 32'h0000_0008);
    chk("jal rd", 32'(out_rd), 32'd1);
    step(1'b0, '0, '0, 1'b1);
    chk("drained valid", 32'(out_valid), 32'd0);
    chk("drained decoded_cnt", 32'(decoded_cnt), 32'd4);

    do_reset();
    step(1'b1, 32'h100, 32'h0, 1'b1);
    chk("illegal op", 32'(out_op), 32'(OP_ILLEGAL));
    step(1'b0, '0, '0, 1'b1);
    chk("illegal illegal_cnt", 32'(illegal_cnt), 32'd1);
    chk("illegal decoded_cnt", 32'(decoded_cnt), 32'd1);

    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 32'h1000 + 32'(4 * i), rand_insn(), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    chk("stream decoded_cnt", 32'(decoded_cnt), 32'd10);

    for (int i = 0; i < 3; i++) step(1'b1, 32'h2000 + 32'(4 * i), rand_insn(), 1'b0);
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst decoded_cnt", 32'(decoded_cnt), 32'd0);
    chk("midrst illegal_cnt", 32'(illegal_cnt), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 3) != 0, $urandom, rand_insn(), $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_disasm_trace.md
# rv_disasm_trace

Buffered RV32 instruction-trace decoder. Accepts retired (pc, instruction) pairs over a valid/ready handshake and queues them in a DEPTH-entry FIFO. It presents each entry as a decoded record: operation, register indices and immediate. Optionally it prints a disassembly line per record using the shared register-name string table. It generalises the single-op, combinational `lui` formatter to a handshaked, multi-opcode, configurable-depth and configurable-naming trace stage. It sits between a core's retire port and the simulation log/checker.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ABI_NAMES`, 1: 1 = ABI register names ("a0"); 0 = numeric names ("x10").
- `CNT_W`, 16: width of the statistics counters.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  pc/insn pair offered.
- `in_ready`  out  1  FIFO can accept.
- `in_pc`  in  32  instruction address.
- `in_insn`  in  32  instruction word.
- `out_valid`  out  1  decoded record available.
- `out_ready`  in  1  consumer takes record.
- `out_pc`  out  32  pc of head record.
- `out_op`  out  op_t  LUI, AUIPC, JAL, ADDI, ADD, ILLEGAL.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  register indices; 0 where the format lacks the field.
- `out_imm`  out  32  decoded immediate.
- `decoded_cnt`  out  CNT_W  records popped.
- `illegal_cnt`  out  CNT_W  ILLEGAL records popped.

## Operation
- Decode happens at push; the FIFO stores decoded records, not raw words.
- LUI: opcode 0110111. `imm = {insn[31:12], 12'b0}`. rd only.
- AUIPC: opcode 0010111. Same immediate as LUI.
- JAL: opcode 1101111. J-immediate sign-extended to 32 bits, bit0 = 0. rd only.
- ADDI: opcode 0010011, funct3 000. `imm = sext(insn[31:20])`. rd and rs1.
- ADD: opcode 0110011, funct3 000, funct7 0000000. rd, rs1 and rs2. imm 0.
- Any other word is ILLEGAL. All index fields 0, imm 0.
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- `in_ready = !full`, with no full-bypass: when full, push is refused even if a pop occurs in the same cycle.
- `out_valid = !empty`. Output fields are driven from the head entry. Fields are don't-care while `out_valid` = 0, but the bench must see them held at the last value or 0 (no X).
- Simultaneous push and pop when neither empty nor full: both take effect and occupancy is unchanged.
- Counters increment on pop and wrap modulo 2^CNT_W.

## Timing
- Latency: a push in cycle N gives `out_valid` = 1 in cycle N+1.
- Throughput: 1 record/cycle when `out_ready` is held high.
- `in_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.
- Pointers are log2(DEPTH) bits and wrap naturally. An occupancy counter of log2(DEPTH)+1 bits distinguishes full from empty.
- Reset values: pointers 0, occupancy 0, `out_valid` 0, `in_ready` 1, counters 0, storage don't-care.
- Reset mid-operation: queued records are discarded, no print occurs, and state is as above in the next cycle.

## Configuration
- `RV_DISASM_TRACE_EN` defined: on every pop, `$display` prints "PC: 0x%08x: %s", with mnemonic padded to 6 characters and operands comma-separated.
  - Operands use names from the table selected by `ABI_NAMES`.
  - Immediates print as 0x%08x.
  - ILLEGAL prints "illegal".
- `RV_DISASM_TRACE_EN` undefined: no display or string logic is compiled. All ports behave identically.

## Structure
- Package `rv_trace_pkg` holds:
  - `op_t` enum.
  - `trace_rec_t` packed struct: pc, op, rd, rs1, rs2, imm.
  - The `decode()` function.
  - localparam string arrays `REG_ABI[0:31]` and `REG_NUM[0:31]`.
  - The `disasm()` function, inside the `RV_DISASM_TRACE_EN` guard.
- Sub-module `rv_trace_fifo`: generic DEPTH×`trace_rec_t` synchronous FIFO with full, empty and count outputs. The top level holds decode, counters and print.

## Test plan
- Push insn 0x12345537 at pc 0x80000000 -> next cycle the record is LUI, rd 10, imm 0x12345000. With the macro defined, the log shows "lui   a0, 0x12345000"; with `ABI_NAMES`=0 it shows "x10".
- Push 0xFF010113 -> ADDI, rd 2, rs1 2, imm 0xFFFFFFF0. Push 0x007302B3 -> ADD, rd 5, rs1 6, rs2 7.
- Hold `out_ready`=0 and push 4 records -> `in_ready`=0 after the 4th. A 5th offer is not accepted. One pop -> `in_ready`=1 next cycle, and records emerge in FIFO order.
- Push 0x00000000 and pop -> ILLEGAL, `illegal_cnt`=1, `decoded_cnt`=1.
- Stream 10 records back-to-back with `out_ready` high -> 10 pops on consecutive cycles, `decoded_cnt`=10, no refused push.
- Fill 3 entries, then assert `rst` for one cycle -> `out_valid`=0, `in_ready`=1, counters 0, and nothing printed.
